// File: rtl/subsurf_pkg.sv
// Shared SRAM geometry and requester indices for the subsurface mesh pipeline.
package subsurf_pkg;
  localparam int RAM_AW  = 9;
  localparam int RAM_DW  = 32;
  localparam int RAM_WEW = 4;

  localparam int REQ_NBR  = 0;
  localparam int REQ_AVG  = 1;
  localparam int REQ_HOST = 2;

  localparam int LOCK_MAX_DEFAULT = 16;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side and SRAM-side bus of one shared macro port.
interface ram_port_arbiter_if #(
  parameter int N_REQ = 3
);
  import subsurf_pkg::*;

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_lock;
  logic [N_REQ*RAM_AW-1:0]  req_addr;
  logic [N_REQ*RAM_WEW-1:0] req_we;
  logic [N_REQ*RAM_DW-1:0]  req_wdata;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ-1:0]         rsp_valid;
  logic [RAM_DW-1:0]        rsp_rdata;
  logic                     ram_en;
  logic [RAM_AW-1:0]        ram_a;
  logic [RAM_WEW-1:0]       ram_we;
  logic [RAM_DW-1:0]        ram_di;
  logic [RAM_DW-1:0]        ram_do;

  modport slave (
    input  req_valid, req_lock, req_addr, req_we, req_wdata, ram_do,
    output req_ready, rsp_valid, rsp_rdata, ram_en, ram_a, ram_we, ram_di
  );

  modport master (
    output req_valid, req_lock, req_addr, req_we, req_wdata, ram_do,
    input  req_ready, rsp_valid, rsp_rdata, ram_en, ram_a, ram_we, ram_di
  );
endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// Rotating-priority one-hot picker: first set valid bit scanning from ptr upward, wrapping.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port among N_REQ requesters, with bounded
// locked bursts and one-cycle read responses routed back to the issuer.
module ram_port_arbiter
  import subsurf_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus,
  output logic              busy
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  if (N_REQ < 2 || N_REQ > 4) begin : g_bad_n_req
    $error("ram_port_arbiter: N_REQ must be in 2..4");
  end

  logic [PTR_W-1:0] ptr;
  logic             owner_vld;
  logic [PTR_W-1:0] owner_idx;
  logic [CNT_W-1:0] lock_cnt;
  logic [N_REQ-1:0] rd_pend;

  logic [N_REQ-1:0]   pick;
  logic [N_REQ-1:0]   grant;
  logic [PTR_W-1:0]   sel;
  logic [RAM_WEW-1:0] sel_we;
  logic               sel_lock;

  rr_pick #(.N(N_REQ), .PW(PTR_W)) u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr),
    .grant (pick)
  );

  always_comb begin
    grant = '0;
    if (!rst) begin
      if (owner_vld) grant[owner_idx] = bus.req_valid[owner_idx];
      else           grant = pick;
    end
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel = PTR_W'(i);
    end
    sel_we   = bus.req_we[sel*RAM_WEW +: RAM_WEW];
    sel_lock = bus.req_lock[sel];

    bus.ram_en = |grant;
    bus.ram_a  = '0;
    bus.ram_we = '0;
    bus.ram_di = '0;
    if (|grant) begin
      bus.ram_a  = bus.req_addr[sel*RAM_AW +: RAM_AW];
      bus.ram_we = sel_we;
      bus.ram_di = bus.req_wdata[sel*RAM_DW +: RAM_DW];
    end

    bus.req_ready = grant;
    bus.rsp_valid = rst ? '0 : rd_pend;
    bus.rsp_rdata = bus.ram_do;
    busy          = (|bus.req_valid) | owner_vld | (|rd_pend);
  end

  // Accept stage: ownership, lock budget, rotation pointer and response tag
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      owner_vld <= 1'b0;
      owner_idx <= '0;
      lock_cnt  <= '0;
      rd_pend   <= '0;
    end else if (|grant) begin
      // Forced release at the last allowed locked grant keeps others' wait bounded
      if (sel_lock && lock_cnt < CNT_W'(LOCK_MAX - 1)) begin
        owner_vld <= 1'b1;
        owner_idx <= sel;
        lock_cnt  <= lock_cnt + 1'b1;
      end else begin
        owner_vld <= 1'b0;
        lock_cnt  <= '0;
        ptr       <= (sel == PTR_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
      end
      rd_pend <= (sel_we == '0) ? grant : '0;
    end else begin
      rd_pend <= '0;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: N_REQ=3, LOCK_MAX=4, behavioral SRAM model.
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.N_REQ(3)) bus ();

  ram_port_arbiter #(.N_REQ(3), .LOCK_MAX(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  typedef struct packed {
    logic [2:0]  oh;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem[512];
  logic [31:0] shadow[512];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A000000 + 32'(i) * 32'h00010101;
  endfunction

  // SRAM macro model: synchronous read, byte-enabled write
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
    end else if (bus.ram_en) begin
      if (bus.ram_we == 4'b0000) bus.ram_do <= mem[bus.ram_a];
      for (int b = 0; b < 4; b++)
        if (bus.ram_we[b]) mem[bus.ram_a][b*8 +: 8] <= bus.ram_di[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input bit v, input bit lk, input logic [8:0] a,
                         input logic [3:0] w, input logic [31:0] d);
    bus.req_valid[k]          = v;
    bus.req_lock[k]           = lk;
    bus.req_addr[k*9 +: 9]    = a;
    bus.req_we[k*4 +: 4]      = w;
    bus.req_wdata[k*32 +: 32] = d;
  endtask

  task automatic clear_all();
    for (int k = 0; k < 3; k++) set_req(k, 1'b0, 1'b0, 9'h0, 4'h0, 32'h0);
  endtask

  // Checks one cycle mid-period, records expectations, then advances to the next negedge
  task automatic tick(input logic [2:0] exp_g, input string tag);
    exp_t        e;
    int          k;
    logic [8:0]  a;
    logic [3:0]  w;
    logic [31:0] d;
    #1;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 512; i++) shadow[i] = init_word(i);
      chk({tag, ".rspv"}, 32'(bus.rsp_valid), 32'h0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".rspv"}, 32'(bus.rsp_valid), 32'(e.oh));
      chk({tag, ".rdata"}, bus.rsp_rdata, e.d);
    end else begin
      chk({tag, ".rspv"}, 32'(bus.rsp_valid), 32'h0);
    end
    chk({tag, ".gnt"}, 32'(bus.req_ready), 32'(exp_g));
    chk({tag, ".en"}, 32'(bus.ram_en), 32'(|exp_g));
    if (exp_g != 3'b000 && !rst) begin
      k = exp_g[0] ? 0 : (exp_g[1] ? 1 : 2);
      a = bus.req_addr[k*9 +: 9];
      w = bus.req_we[k*4 +: 4];
      d = bus.req_wdata[k*32 +: 32];
      chk({tag, ".addr"}, 32'(bus.ram_a), 32'(a));
      if (w == 4'b0000) begin
        e.oh = exp_g;
        e.d  = shadow[a];
        exp_q.push_back(e);
      end else begin
        for (int b = 0; b < 4; b++) if (w[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_all();
    rst = 1'b1;
    tick(3'b000, "rst");
    rst = 1'b0;
  endtask

  logic [2:0] rr_seq[6];
  logic [2:0] all_gnt;

  initial begin
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    clear_all();
    @(negedge clk);
    tick(3'b000, "rst0");
    rst = 1'b0;
    #1 chk("idle_busy", 32'(busy), 32'h0);

    // single read with zero-latency grant and one-cycle response
    set_req(0, 1'b1, 1'b0, 9'h005, 4'h0, 32'h0);
    tick(3'b001, "rd1");
    clear_all();
    tick(3'b000, "rd1_rsp");

    // fair rotation with everyone continuously requesting
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 3; k++) set_req(k, 1'b1, 1'b0, 9'(9'h020 + i*3 + k), 4'h0, 32'h0);
      tick(rr_seq[i], $sformatf("rr%0d", i));
    end
    clear_all();
    tick(3'b000, "rr_tail");

    // locked write burst by requester 1 while 0 and 2 keep requesting
    set_req(0, 1'b1, 1'b0, 9'h040, 4'h0, 32'h0);
    tick(3'b001, "pre_lock");
    set_req(2, 1'b1, 1'b0, 9'h041, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      set_req(1, 1'b1, i < 3, 9'(9'h010 + i), 4'hF, 32'h11110000 + 32'(i));
      tick(3'b010, $sformatf("burst%0d", i));
    end
    set_req(1, 1'b0, 1'b0, 9'h0, 4'h0, 32'h0);
    tick(3'b100, "after_burst2");
    tick(3'b001, "after_burst0");
    clear_all();
    tick(3'b000, "burst_tail");

    // forced release after LOCK_MAX grants, then idle owner still blocks others
    do_reset();
    set_req(0, 1'b1, 1'b1, 9'h050, 4'h0, 32'h0);
    set_req(2, 1'b1, 1'b0, 9'h060, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) tick(3'b001, $sformatf("hold%0d", i));
    tick(3'b100, "forced2");
    tick(3'b001, "relock0");
    clear_all();
    #1 chk("lock_idle_busy", 32'(busy), 32'h1);
    set_req(2, 1'b1, 1'b0, 9'h061, 4'h0, 32'h0);
    tick(3'b000, "lock_wait");
    set_req(0, 1'b1, 1'b0, 9'h051, 4'h0, 32'h0);
    tick(3'b001, "unlock0");
    set_req(0, 1'b0, 1'b0, 9'h0, 4'h0, 32'h0);
    tick(3'b100, "waiter2");
    clear_all();
    tick(3'b000, "lock_tail");

    // write then read the same word, full and partial byte enables
    set_req(2, 1'b1, 1'b0, 9'h1AB, 4'hF, 32'hDEADBEEF);
    tick(3'b100, "wr_full");
    set_req(2, 1'b1, 1'b0, 9'h1AB, 4'h0, 32'h0);
    tick(3'b100, "rd_full");
    clear_all();
    #1 chk("deadbeef", bus.rsp_rdata, 32'hDEADBEEF);
    tick(3'b000, "rd_full_rsp");
    set_req(2, 1'b1, 1'b0, 9'h1AB, 4'b0011, 32'h12345678);
    tick(3'b100, "wr_part");
    set_req(2, 1'b1, 1'b0, 9'h1AB, 4'h0, 32'h0);
    tick(3'b100, "rd_part");
    clear_all();
    #1 chk("dead5678", bus.rsp_rdata, 32'hDEAD5678);
    tick(3'b000, "rd_part_rsp");

    // reset right after an accepted read drops its response
    set_req(1, 1'b1, 1'b0, 9'h077, 4'h0, 32'h0);
    tick(3'b010, "rd_before_rst");
    set_req(1, 1'b0, 1'b0, 9'h0, 4'h0, 32'h0);
    set_req(0, 1'b1, 1'b0, 9'h078, 4'h0, 32'h0);
    rst = 1'b1;
    tick(3'b000, "rst_mid");
    rst = 1'b0;
    clear_all();
    #1 chk("post_rst_busy", 32'(busy), 32'h0);
    tick(3'b000, "post_rst");
    all_gnt = 3'b111;
    for (int k = 0; k < 3; k++) set_req(k, all_gnt[k], 1'b0, 9'(9'h080 + k), 4'h0, 32'h0);
    tick(3'b001, "ptr0");
    clear_all();
    tick(3'b000, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
